// File: rtl/load_run_ctrl_if.sv
// load_run_ctrl_if: load/run sequencing bus between the controller and its host/core side.
interface load_run_ctrl_if #(parameter int AW = 4);
  logic ena;
  logic proc_en;
  logic csi;
  logic csd;
  logic mosi;
  logic core_halt;
  logic imem_we;
  logic dmem_we;
  logic [AW-1:0] waddr;
  logic [7:0] wdata;
  logic core_rst_n;
  logic core_run;
  logic done;
  logic timeout;
  logic [7:0] cycles;
  modport slave (
    input ena, proc_en, csi, csd, mosi, core_halt,
    output imem_we, dmem_we, waddr, wdata, core_rst_n, core_run, done, timeout, cycles
  );
  modport master (
    output ena, proc_en, csi, csd, mosi, core_halt,
    input imem_we, dmem_we, waddr, wdata, core_rst_n, core_run, done, timeout, cycles
  );
endinterface

// File: rtl/load_run_ctrl.sv
// load_run_ctrl: serial program/data loader and run sequencer with cycle watchdog.
module load_run_ctrl #(
  parameter int IMEM_AW = 4,
  parameter int DMEM_AW = 4,
  parameter int MAX_CYCLES = 255
) (
  input logic clk,
  input logic rst_n,
  load_run_ctrl_if.slave bus
);
  localparam int WAW = (IMEM_AW > DMEM_AW) ? IMEM_AW : DMEM_AW;
  localparam logic [WAW-1:0] IMASK = WAW'((1 << IMEM_AW) - 1);
  localparam logic [WAW-1:0] DMASK = WAW'((1 << DMEM_AW) - 1);
  localparam logic [7:0] MAXC = 8'(MAX_CYCLES);
  typedef enum logic [2:0] {IDLE, LOAD_I, LOAD_D, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d;
  logic [WAW-1:0] addr_q, addr_d;
  logic imem_we_q, imem_we_d;
  logic dmem_we_q, dmem_we_d;
  logic [WAW-1:0] waddr_q, waddr_d;
  logic [7:0] wdata_q, wdata_d;
  logic core_rst_n_q, core_rst_n_d;
  logic core_run_q, core_run_d;
  logic done_q, done_d;
  logic timeout_q, timeout_d;
  logic [7:0] cycles_q, cycles_d;
  logic sel;
  logic [7:0] cyc_inc;
  always_comb begin
    state_d = state_q;
    bit_d = bit_q;
    shift_d = shift_q;
    addr_d = addr_q;
    imem_we_d = 1'b0;
    dmem_we_d = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    timeout_d = timeout_q;
    cycles_d = cycles_q;
    sel = (state_q == LOAD_I) ? (bus.csi && !bus.csd) : (bus.csd && !bus.csi);
    cyc_inc = (cycles_q == 8'hff) ? cycles_q : cycles_q + 8'd1;
    if (!bus.ena) begin
      state_d = IDLE;
      waddr_d = '0;
      wdata_d = '0;
      timeout_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          bit_d = '0;
          shift_d = '0;
          addr_d = '0;
          timeout_d = 1'b0;
          if (bus.csi && !bus.csd) state_d = LOAD_I;
          else if (bus.csd && !bus.csi) state_d = LOAD_D;
          else if (!bus.csi && !bus.csd && bus.proc_en) begin
            state_d = RUN;
            cycles_d = '0;
          end
        end
        LOAD_I, LOAD_D: begin
          if (!sel) state_d = IDLE;
          else begin
            shift_d = {shift_q[6:0], bus.mosi};
            bit_d = bit_q + 3'd1;
            // 8th bit of the byte: strobe the completed byte out on this edge
            if (bit_q == 3'd7) begin
              imem_we_d = (state_q == LOAD_I);
              dmem_we_d = (state_q == LOAD_D);
              waddr_d = addr_q;
              wdata_d = shift_d;
              addr_d = (addr_q + WAW'(1)) & ((state_q == LOAD_I) ? IMASK : DMASK);
            end
          end
        end
        RUN: begin
          cycles_d = cyc_inc;
          if (!bus.proc_en) state_d = IDLE;
          else if (bus.core_halt) state_d = DONE;
          else if (cyc_inc >= MAXC) begin
            state_d = DONE;
            timeout_d = 1'b1;
          end
        end
        DONE: begin
          if (!bus.proc_en) begin
            state_d = IDLE;
            timeout_d = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    core_rst_n_d = (state_d == RUN) || (state_d == DONE);
    core_run_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      bit_q <= '0;
      shift_q <= '0;
      addr_q <= '0;
      imem_we_q <= 1'b0;
      dmem_we_q <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      core_rst_n_q <= 1'b0;
      core_run_q <= 1'b0;
      done_q <= 1'b0;
      timeout_q <= 1'b0;
      cycles_q <= '0;
    end else begin
      state_q <= state_d;
      bit_q <= bit_d;
      shift_q <= shift_d;
      addr_q <= addr_d;
      imem_we_q <= imem_we_d;
      dmem_we_q <= dmem_we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      core_rst_n_q <= core_rst_n_d;
      core_run_q <= core_run_d;
      done_q <= done_d;
      timeout_q <= timeout_d;
      cycles_q <= cycles_d;
    end
  end
  assign bus.imem_we = imem_we_q;
  assign bus.dmem_we = dmem_we_q;
  assign bus.waddr = waddr_q;
  assign bus.wdata = wdata_q;
  assign bus.core_rst_n = core_rst_n_q;
  assign bus.core_run = core_run_q;
  assign bus.done = done_q;
  assign bus.timeout = timeout_q;
  assign bus.cycles = cycles_q;
endmodule

// File: tb/tb_load_run_ctrl.sv
// tb_load_run_ctrl: directed load/run scenarios checked against a write scoreboard and run-outcome model.
module tb_load_run_ctrl;
  localparam int MAXC = 20;
  typedef struct packed {
    logic mi;
    logic [3:0] a;
    logic [7:0] d;
  } wr_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int tests = 0;
  int fails = 0;
  wr_t exp_q[$];
  logic [7:0] tx[$];
  load_run_ctrl_if #(.AW(4)) bus ();
  load_run_ctrl #(.IMEM_AW(4), .DMEM_AW(4), .MAX_CYCLES(MAXC)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask
  // Every strobe must match the next write the stimulus announced.
  always @(negedge clk) begin
    if (rst_n) begin
      wr_t e;
      chk("run_needs_core_rst_released", !bus.core_run || bus.core_rst_n, 1);
      chk("done_stops_core", !(bus.done && bus.core_run), 1);
      chk("timeout_implies_done", !bus.timeout || bus.done, 1);
      chk("single_strobe", bus.imem_we && bus.dmem_we, 0);
      if (bus.imem_we || bus.dmem_we) begin
        chk("write_core_held", bus.core_rst_n, 0);
        chk("write_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("write_mem_i", bus.imem_we, e.mi);
          chk("write_addr", bus.waddr, e.a);
          chk("write_data", bus.wdata, e.d);
        end
      end
    end
  end
  task automatic chk_reset_outs(input string tag, input bit with_cycles);
    chk({tag, "_imem_we"}, bus.imem_we, 0);
    chk({tag, "_dmem_we"}, bus.dmem_we, 0);
    chk({tag, "_waddr"}, bus.waddr, 0);
    chk({tag, "_wdata"}, bus.wdata, 0);
    chk({tag, "_core_rst_n"}, bus.core_rst_n, 0);
    chk({tag, "_core_run"}, bus.core_run, 0);
    chk({tag, "_done"}, bus.done, 0);
    chk({tag, "_timeout"}, bus.timeout, 0);
    if (with_cycles) chk({tag, "_cycles"}, bus.cycles, 0);
  endtask
  task automatic load_seq(input bit is_i);
    wr_t w;
    bus.csi = is_i;
    bus.csd = !is_i;
    @(negedge clk);
    for (int k = 0; k < tx.size(); k++) begin
      w.mi = is_i;
      w.a = 4'(k % 16);
      w.d = tx[k];
      exp_q.push_back(w);
      for (int i = 0; i < 8; i++) begin
        bus.mosi = tx[k][7-i];
        @(negedge clk);
        chk("strobe_timing", bus.imem_we || bus.dmem_we, (i == 7) ? 1 : 0);
      end
    end
    bus.csi = 1'b0;
    bus.csd = 1'b0;
    bus.mosi = 1'b0;
    @(negedge clk);
  endtask
  // Outcome of a run: halt on run edge halt_at (0 = never) against the watchdog.
  task automatic run(input int halt_at, input bit with_csi);
    int k;
    int exp_cyc;
    bit exp_to;
    bit halted;
    halted = (halt_at > 0) && (halt_at <= MAXC);
    exp_cyc = halted ? halt_at : MAXC;
    exp_to = !halted;
    bus.proc_en = 1'b1;
    @(negedge clk);
    chk("run_entry_core_run", bus.core_run, 1);
    chk("run_entry_core_rst_n", bus.core_rst_n, 1);
    chk("run_entry_cycles", bus.cycles, 0);
    k = 0;
    while (k < 300 && !bus.done) begin
      k++;
      bus.core_halt = (k == halt_at);
      if (with_csi) begin
        bus.csi = 1'b1;
        bus.mosi = k[0];
      end
      @(negedge clk);
    end
    bus.core_halt = 1'b0;
    bus.csi = 1'b0;
    bus.mosi = 1'b0;
    chk("run_len", k, exp_cyc);
    chk("run_done", bus.done, 1);
    chk("run_timeout", bus.timeout, exp_to);
    chk("run_cycles", bus.cycles, exp_cyc);
    chk("done_core_run", bus.core_run, 0);
    chk("done_core_rst_n", bus.core_rst_n, 1);
    repeat (3) @(negedge clk);
    chk("done_cycles_frozen", bus.cycles, exp_cyc);
    chk("done_held", bus.done, 1);
    bus.proc_en = 1'b0;
    @(negedge clk);
    chk("idle_done", bus.done, 0);
    chk("idle_timeout", bus.timeout, 0);
    chk("idle_core_rst_n", bus.core_rst_n, 0);
    chk("idle_cycles_kept", bus.cycles, exp_cyc);
  endtask
  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1);
  end
  initial begin
    bus.ena = 1'b1;
    bus.proc_en = 1'b0;
    bus.csi = 1'b0;
    bus.csd = 1'b0;
    bus.mosi = 1'b0;
    bus.core_halt = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_outs("reset", 1);
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset_outs("post_reset", 1);
    tx = '{8'hA5, 8'h3C};
    load_seq(1);
    chk("imem_last_addr", bus.waddr, 4'h1);
    chk("imem_last_data", bus.wdata, 8'h3C);
    bus.csd = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      bus.mosi = i[0];
      @(negedge clk);
    end
    bus.csd = 1'b0;
    @(negedge clk);
    tx = '{8'h7E};
    load_seq(0);
    chk("dmem_addr0", bus.waddr, 4'h0);
    chk("dmem_data", bus.wdata, 8'h7E);
    tx.delete();
    for (int k = 0; k < 17; k++) tx.push_back(8'(k * 13 + 1));
    load_seq(1);
    chk("wrap_addr", bus.waddr, 4'h0);
    chk("wrap_data", bus.wdata, 8'hD1);
    bus.csi = 1'b1;
    bus.csd = 1'b1;
    for (int i = 0; i < 12; i++) begin
      bus.mosi = !i[0];
      @(negedge clk);
      chk("both_sel_held", bus.core_rst_n, 0);
    end
    bus.csd = 1'b0;
    bus.csi = 1'b0;
    @(negedge clk);
    bus.csi = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      bus.mosi = 1'b1;
      @(negedge clk);
    end
    bus.csd = 1'b1;
    for (int i = 0; i < 6; i++) @(negedge clk);
    bus.csi = 1'b0;
    bus.csd = 1'b0;
    @(negedge clk);
    tx = '{8'hC3};
    load_seq(0);
    run(10, 0);
    chk("halt_cycles_lit", bus.cycles, 8'd10);
    run(0, 0);
    chk("wdog_cycles_lit", bus.cycles, 8'd20);
    run(MAXC, 0);
    run(7, 1);
    chk("csi_in_run_cycles_lit", bus.cycles, 8'd7);
    tx = '{8'h11, 8'h22};
    load_seq(1);
    bus.csi = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      bus.mosi = 1'b1;
      @(negedge clk);
    end
    #2 rst_n = 1'b0;
    #1 chk_reset_outs("rst_mid_byte", 1);
    bus.csi = 1'b0;
    bus.mosi = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tx = '{8'h5A};
    load_seq(1);
    chk("after_rst_addr", bus.waddr, 4'h0);
    chk("after_rst_data", bus.wdata, 8'h5A);
    bus.proc_en = 1'b1;
    repeat (4) @(negedge clk);
    chk("pre_rst_run", bus.core_run, 1);
    #2 rst_n = 1'b0;
    #1 chk_reset_outs("rst_mid_run", 1);
    bus.proc_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    bus.proc_en = 1'b1;
    repeat (5) @(negedge clk);
    chk("pre_ena_run", bus.core_run, 1);
    bus.ena = 1'b0;
    @(negedge clk);
    chk_reset_outs("ena_low", 0);
    bus.proc_en = 1'b0;
    @(negedge clk);
    bus.ena = 1'b1;
    @(negedge clk);
    chk("ena_back_idle", bus.core_rst_n, 0);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
